// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit port: FSM states,
// default port IDs, status register bit positions and FIFO geometry.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam logic [7:0] DEF_TX_ID   = 8'h40;
  localparam logic [7:0] DEF_STAT_ID = 8'h41;
  localparam logic [7:0] DEF_CTRL_ID = 8'h42;

  // Status register layout: {1'b0, COUNT[2:0], OVF, BUSY, FULL, EMPTY}
  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_BUSY_BIT  = 2;
  localparam int STAT_OVF_BIT   = 3;
  localparam int STAT_COUNT_LSB = 4;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_CNT_W = 3;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous first-word-fall-through FIFO. The head entry is always
// visible on rdata_o; a pop is ignored when empty and a push is ignored when
// full unless a pop in the same cycle frees the slot.
module sync_fifo
  import uart_tx_pkg::*;
#(
  parameter  int WIDTH = DATA_W,
  parameter  int DEPTH = FIFO_DEPTH,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next-state for pointers and occupancy.
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards all queued data.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write port.
  // NOTE: the array is deliberately not reset; emptiness is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/uart_tx_port.sv
// MCU-attached UART transmitter: a port-mapped write queues bytes into a
// 4-entry FIFO, a four-state FSM serialises them as 8N1 frames, and a status
// and control register pair is readable through the combinational input mux.
module uart_tx_port
  import uart_tx_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] TX_ID        = DEF_TX_ID,
  parameter logic [7:0] STAT_ID      = DEF_STAT_ID,
  parameter logic [7:0] CTRL_ID      = DEF_CTRL_ID
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] OUT_PORT,
  input  logic [7:0] PORT_ID,
  input  logic       IO_STRB,
  output logic [7:0] IN_PORT,
  output logic       INT,
  output logic       TX
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_e             state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [2:0]            bit_q, bit_d;
  logic [DATA_W-1:0]     shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  int_q, int_d;
  logic                  ie_q, ie_d;
  logic                  ovf_q, ovf_d;

  logic                  push_req, ctrl_wr, fifo_pop;
  logic                  fifo_full, fifo_empty;
  logic [DATA_W-1:0]     fifo_rdata;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic                  baud_wrap, busy;
  logic [7:0]            stat;

  assign push_req  = IO_STRB && (PORT_ID == TX_ID);
  assign ctrl_wr   = IO_STRB && (PORT_ID == CTRL_ID);
  assign baud_wrap = (baud_q == BAUD_LAST);
  assign busy      = (state_q != ST_IDLE);

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RESET_N),
    .push_i  (push_req),
    .pop_i   (fifo_pop),
    .wdata_i (OUT_PORT),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Frame sequencer: the TX level is computed for the next state so the line
  // register changes on the same edge as the state, and a finished stop bit
  // starts the next queued frame without passing through an idle cycle.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    int_d    = 1'b0;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        tx_d   = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          tx_d     = 1'b0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (baud_wrap) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[DATA_W-1:1]};
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[DATA_W-1:1]};
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            tx_d     = 1'b0;
            state_d  = ST_START;
          end else begin
            tx_d    = 1'b1;
            int_d   = ie_q;
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Control register writes and sticky overflow flag.
  always_comb begin
    ie_d  = ie_q;
    ovf_d = ovf_q;
    if (ctrl_wr) begin
      ie_d = OUT_PORT[0];
      if (OUT_PORT[1]) ovf_d = 1'b0;
    end
    if (push_req && fifo_full && !fifo_pop) ovf_d = 1'b1;
  end

  // Sequencer and register state; reset aborts any frame and idles the line high.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      int_q   <= 1'b0;
      ie_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      int_q   <= int_d;
      ie_q    <= ie_d;
      ovf_q   <= ovf_d;
    end
  end

  // Status word assembly.
  always_comb begin
    stat                                      = '0;
    stat[STAT_EMPTY_BIT]                      = fifo_empty;
    stat[STAT_FULL_BIT]                       = fifo_full;
    stat[STAT_BUSY_BIT]                       = busy;
    stat[STAT_OVF_BIT]                        = ovf_q;
    stat[STAT_COUNT_LSB +: FIFO_CNT_W]        = fifo_count;
  end

  // Read mux toward the MCU input port.
  always_comb begin
    IN_PORT = 8'h00;
    if (PORT_ID == STAT_ID) begin
      IN_PORT = stat;
    end else if (PORT_ID == CTRL_ID) begin
      IN_PORT = {7'b0, ie_q};
    end
  end

  assign TX  = tx_q;
  assign INT = int_q;

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed bench for uart_tx_port with CLKS_PER_BIT=4: frame timing and bit
// order, interrupt pulse, FIFO overflow/full behaviour, back-to-back frames,
// control register, and asynchronous reset mid-frame.
module tb_uart_tx_port;

  localparam int         CPB     = 4;
  localparam logic [7:0] TX_ID   = 8'h40;
  localparam logic [7:0] STAT_ID = 8'h41;
  localparam logic [7:0] CTRL_ID = 8'h42;

  logic       CLK;
  logic       RESET_N;
  logic [7:0] OUT_PORT;
  logic [7:0] PORT_ID;
  logic       IO_STRB;
  logic [7:0] IN_PORT;
  logic       INT;
  logic       TX;

  int checks = 0;
  int errors = 0;

  uart_tx_port #(
    .CLKS_PER_BIT (CPB),
    .TX_ID        (TX_ID),
    .STAT_ID      (STAT_ID),
    .CTRL_ID      (CTRL_ID)
  ) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .OUT_PORT (OUT_PORT),
    .PORT_ID  (PORT_ID),
    .IO_STRB  (IO_STRB),
    .IN_PORT  (IN_PORT),
    .INT      (INT),
    .TX       (TX)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Called 1 ns after an edge; the write is taken on the following edge.
  task automatic write(input logic [7:0] id, input logic [7:0] data);
    PORT_ID  = id;
    OUT_PORT = data;
    IO_STRB  = 1'b1;
    step();
    IO_STRB  = 1'b0;
  endtask

  task automatic read(input logic [7:0] id, output logic [7:0] data);
    PORT_ID = id;
    #1;
    data = IN_PORT;
  endtask

  // Called during the first cycle of a frame (start bit already on the line);
  // checks all 40 bit-cycles and returns during the last stop-bit cycle.
  task automatic frame_check(input string tag, input logic [7:0] d);
    logic [7:0] st;
    logic       exp_tx;
    int         b;
    for (int i = 0; i < 10 * CPB; i++) begin
      b = i / CPB;
      if (b == 0)      exp_tx = 1'b0;
      else if (b == 9) exp_tx = 1'b1;
      else             exp_tx = d[b-1];
      check($sformatf("%s_tx%0d", tag, i), TX, exp_tx);
      check($sformatf("%s_int%0d", tag, i), INT, 1'b0);
      read(STAT_ID, st);
      check($sformatf("%s_busy%0d", tag, i), st[2], 1'b1);
      if (i < 10 * CPB - 1) step();
    end
  endtask

  logic [7:0] rd;
  int         tx_lows;

  initial begin
    RESET_N  = 1'b1;
    OUT_PORT = 8'h00;
    PORT_ID  = 8'h00;
    IO_STRB  = 1'b0;
    #1 RESET_N = 1'b0;
    #1;

    // Reset state
    check("rst_tx", TX, 1'b1);
    check("rst_int", INT, 1'b0);
    read(STAT_ID, rd); check("rst_stat", rd, 8'h01);
    read(CTRL_ID, rd); check("rst_ctrl", rd, 8'h00);
    read(8'h43, rd);   check("rst_other", rd, 8'h00);
    read(TX_ID, rd);   check("rst_txid_read", rd, 8'h00);

    #20 RESET_N = 1'b1;
    step();

    // Single frame A5, IE=0: line falls one edge after the write
    write(TX_ID, 8'hA5);
    check("a5_pre_fall", TX, 1'b1);
    step();
    frame_check("a5", 8'hA5);
    step();
    check("a5_idle_tx", TX, 1'b1);
    check("a5_no_int", INT, 1'b0);
    read(STAT_ID, rd); check("a5_idle_stat", rd, 8'h01);

    // Interrupt pulse after stop completes with IE=1
    write(CTRL_ID, 8'h01);
    read(CTRL_ID, rd); check("ie_set", rd, 8'h01);
    check("ie_no_pending", INT, 1'b0);
    write(TX_ID, 8'h3C);
    step();
    frame_check("3c", 8'h3C);
    step();
    check("3c_int_pulse", INT, 1'b1);
    step();
    check("3c_int_drop", INT, 1'b0);

    // Two queued bytes: zero gap, INT only after the second frame
    write(TX_ID, 8'h81);
    write(TX_ID, 8'h7E);
    frame_check("b2b0", 8'h81);
    step();
    frame_check("b2b1", 8'h7E);
    step();
    check("b2b_end_tx", TX, 1'b1);
    check("b2b_end_int", INT, 1'b1);
    read(STAT_ID, rd); check("b2b_end_stat", rd, 8'h01);
    step();
    check("b2b_int_drop", INT, 1'b0);

    // Five consecutive writes fill the FIFO without overflow
    write(TX_ID, 8'h11);
    write(TX_ID, 8'h22);
    write(TX_ID, 8'h33);
    write(TX_ID, 8'h44);
    write(TX_ID, 8'h55);
    check("fill_started", TX, 1'b0);
    read(STAT_ID, rd); check("fill_stat", rd, 8'h46);
    write(TX_ID, 8'h66);
    write(TX_ID, 8'h77);
    read(STAT_ID, rd); check("ovf_stat", rd, 8'h4E);

    // Clear OVF via control bit1; IE takes bit0=0
    write(CTRL_ID, 8'h02);
    read(STAT_ID, rd); check("ovf_clr_stat", rd, 8'h46);
    read(CTRL_ID, rd); check("ovf_clr_ctrl", rd, 8'h00);

    // Push into a full FIFO on the edge that pops it: accepted, no OVF
    repeat (33) step();
    write(TX_ID, 8'h88);
    read(STAT_ID, rd); check("pushpop_full_stat", rd, 8'h46);
    frame_check("q22", 8'h22);
    step();

    // Reset mid-DATA of 33 with three bytes queued
    repeat (13) step();
    check("mid_data_tx", TX, 1'b0);
    read(STAT_ID, rd); check("mid_data_stat", rd, 8'h34);
    RESET_N = 1'b0;
    #1;
    check("async_rst_tx", TX, 1'b1);
    check("async_rst_int", INT, 1'b0);
    read(STAT_ID, rd); check("async_rst_stat", rd, 8'h01);
    repeat (2) @(posedge CLK);
    #3 RESET_N = 1'b1;
    step();
    tx_lows = 0;
    for (int i = 0; i < 60; i++) begin
      if (TX !== 1'b1) tx_lows++;
      step();
    end
    check("post_rst_no_frames", tx_lows, 0);
    read(STAT_ID, rd); check("post_rst_stat", rd, 8'h01);
    read(CTRL_ID, rd); check("post_rst_ctrl", rd, 8'h00);

    // First write after reset behaves like a fresh start
    write(TX_ID, 8'h5A);
    check("5a_pre_fall", TX, 1'b1);
    step();
    frame_check("5a", 8'h5A);
    step();
    check("5a_idle_tx", TX, 1'b1);
    check("5a_no_int", INT, 1'b0);
    read(STAT_ID, rd); check("5a_idle_stat", rd, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
